ram_rmw_master: RTL and testbench
=================================

# ram_rmw_master

Single-port request initiator that drives one port of the team's dual-port block RAM. The RAM accepts only full-word writes (we = 4'b0000 or 4'b1111) and returns registered read data one cycle after an enabled access; on a write it returns the written word. This block accepts byte-enabled load/store requests from the core-side LSU and issues the matching RAM port accesses. Partial-byte stores become a read-modify-write sequence, so the RAM never sees a partial byte enable.

## Interface
Parameters:
- SCALE, 10, word-address width; must match the attached RAM port.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_addr  in  SCALE  word address.
- req_wdata  in  32  store data, byte lanes aligned to the word.
- req_be  in  4  byte enables; 4'b0000 = load, 4'b1111 = full store, anything else = partial store.
- resp_valid  out  1  one-cycle pulse: the request is complete.
- resp_rdata  out  32  load data, or the final stored word for stores; 0 when resp_valid=0.
- ram_oe  out  1  to RAM oe.
- ram_addr  out  SCALE  to RAM addr.
- ram_wdata  out  32  to RAM wdata.
- ram_we  out  4  to RAM we; only ever 4'b0000 or 4'b1111.
- ram_rdata  in  32  from RAM rdata, registered inside the RAM.

## Operation
States are IDLE, MERGE and RESP. The state register and the latched fields (a_addr, a_wdata, a_be) reset asynchronously to IDLE and zeros.

IDLE:
- req_ready = 1.
- When req_valid=1, the request is accepted and latched, and the RAM access is issued in the same cycle (combinational from req_*):
  - ram_oe = 1
  - ram_addr = req_addr
  - ram_wdata = req_wdata
  - ram_we = 4'b1111 if req_be == 4'b1111, else 4'b0000
- Next state: MERGE if req_be is partial, else RESP.
- When req_valid=0, all ram_* outputs are 0.

MERGE:
- req_ready = 0.
- ram_rdata holds the old word at a_addr.
- Issue ram_oe = 1, ram_addr = a_addr, ram_we = 4'b1111.
- ram_wdata is merged per byte i: a_be[i] ? a_wdata[8i+7:8i] : ram_rdata[8i+7:8i].
- Next state: RESP.

RESP:
- req_ready = 0, ram_oe = 0, ram_we = 0.
- resp_valid = 1 and resp_rdata = ram_rdata. This is the load data, the full-store data, or the merged word (the RAM echoes written data).
- Next state: IDLE.

Other rules:
- Outside IDLE, ram_addr and ram_wdata are 0 unless the state's rule above sets them.
- The block does not hold off on a response; the consumer must always accept resp_valid.
- Address or data traffic on the other RAM port between the MERGE read and write is not detected. Software or arbitration must prevent same-address access during a partial store.

## Timing
- Reset values while rst=0: req_ready=0, resp_valid=0, resp_rdata=0, ram_oe=0, ram_we=0, ram_addr=0, ram_wdata=0. State is IDLE at the first clk edge after release.
- Load and full store: accept in cycle N, resp_valid in N+1, next accept possible in N+2. Throughput is 1 request per 2 cycles.
- Partial store: accept in N, merged write in N+1, resp_valid in N+2, next accept in N+3.
- req_valid may drop or change freely while req_ready=0; it is ignored then.
- Reset asserted mid-operation: state goes to IDLE immediately and ram_oe drops combinationally.
  - If rst falls during MERGE before the clk edge, the merged write is not performed and the RAM word keeps its old value.
  - No resp_valid is produced for the aborted request.
- Back-to-back requests to the same address are safe, because each merge reads after the prior write has completed.

## Test plan
- Load: preload RAM[5]=32'hDEADBEEF; request addr=5, be=0000 -> ram_oe=1, we=0000 in cycle N; resp_valid=1, resp_rdata=32'hDEADBEEF in N+1; req_ready=0 in N+1 and 1 in N+2.
- Full store: addr=7, wdata=32'h01234567, be=1111 -> single RAM access with we=1111 in N; resp_rdata=32'h01234567 in N+1; a subsequent load of 7 returns 32'h01234567.
- Partial store: RAM[3]=32'hAABBCCDD; addr=3, wdata=32'h11223344, be=0101 -> read in N; write of 32'hAA22CC44 with we=1111 in N+1; resp_rdata=32'hAA22CC44 in N+2; ram_we never equals 0101.
- Back-to-back: partial stores be=0001 then be=1000 to addr 9 (initial 32'h00000000, data 32'hFFFFFFFF) with req_valid held high -> second accepted in N+3; final RAM[9]=32'hFF0000FF.
- Reset abort: assert rst during MERGE of a partial store to addr 3 -> no resp_valid, RAM[3] unchanged, all outputs 0 while rst=0, req_ready=1 on the first edge after release.
- Randomized check: 1000 random addr/wdata/be requests against a byte-lane reference memory -> every resp_rdata matches, and ram_we is only ever 0000 or 1111.

Source files
------------

// File: rtl/ram_rmw_master.sv
// ram_rmw_master: byte-enabled load/store initiator for one port of a full-word-only block RAM.
// Partial-byte stores are turned into a read followed by a merged full-word write.
module ram_rmw_master #(
  parameter int SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SCALE-1:0] req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             ram_oe,
  output logic [SCALE-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_we,
  input  logic [31:0]      ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_FULL = 4'b1111;

  function automatic logic be_partial(input logic [3:0] be);
    return (be != BE_NONE) && (be != BE_FULL);
  endfunction

  // Enabled lanes take the new store data, the rest keep the word read back from the RAM.
  function automatic logic [31:0] merge_word(input logic [3:0]  be,
                                             input logic [31:0] new_w,
                                             input logic [31:0] old_w);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
      else       m[8*i +: 8] = old_w[8*i +: 8];
    end
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [SCALE-1:0] a_addr_q, a_addr_d;
  logic [31:0]      a_wdata_q, a_wdata_d;
  logic [3:0]       a_be_q, a_be_d;

  // State register and latched request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      a_addr_q  <= {SCALE{1'b0}};
      a_wdata_q <= 32'd0;
      a_be_q    <= 4'b0000;
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      a_wdata_q <= a_wdata_d;
      a_be_q    <= a_be_d;
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;
    a_be_d    = a_be_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_addr_d  = req_addr;
          a_wdata_d = req_wdata;
          a_be_d    = req_be;
          state_d   = be_partial(req_be) ? ST_MERGE : ST_RESP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_MERGE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; reset forces everything low combinationally so an aborted merge never writes.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    ram_oe     = 1'b0;
    ram_addr   = {SCALE{1'b0}};
    ram_wdata  = 32'd0;
    ram_we     = BE_NONE;
    if (!rst) begin
      req_ready = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            ram_oe    = 1'b1;
            ram_addr  = req_addr;
            ram_wdata = req_wdata;
            ram_we    = (req_be == BE_FULL) ? BE_FULL : BE_NONE;
          end else begin
            ram_oe    = 1'b0;
          end
        end
        ST_MERGE: begin
          ram_oe    = 1'b1;
          ram_addr  = a_addr_q;
          ram_wdata = merge_word(a_be_q, a_wdata_q, ram_rdata);
          ram_we    = BE_FULL;
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = ram_rdata;
        end
        default: begin
          req_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rmw_master.sv
// Directed and random bench for ram_rmw_master with a behavioural registered RAM
// and a byte-lane reference memory.
module tb_ram_rmw_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_oe;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [31:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  ram_rmw_master #(.SCALE(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered RAM port: write echoes the written word, read returns the stored word.
  always @(posedge clk) begin
    if (ram_oe) begin
      if (ram_we == 4'hF) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [3:0] be, input logic [31:0] nw,
                                            input logic [31:0] ow);
    logic [31:0] r;
    r = ow;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Every cycle: only full-word write enables, and response data quiet when not valid.
  always @(negedge clk) begin
    chk("we_legal", {31'd0, (ram_we == 4'h0) || (ram_we == 4'hF)}, 32'd1);
    chk("rdata_quiet", resp_valid ? 32'd0 : resp_rdata, 32'd0);
  end

  task automatic do_req(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] exp;
    logic        part;
    int          lat;
    bit          got;
    part = (be != 4'h0) && (be != 4'hF);
    if (be == 4'h0) exp = ref_mem[a];
    else begin
      exp = ref_merge(be, d, ref_mem[a]);
      ref_mem[a] = exp;
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    chk("req_ready", req_ready, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
      else lat++;
    end
    chk("resp_seen", {31'd0, got}, 32'd1);
    chk("resp_lat", lat, part ? 32'd2 : 32'd1);
    chk("resp_rdata", resp_rdata, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rst = 1'b0; req_valid = 1'b1; req_addr = 10'd5; req_wdata = 32'h55; req_be = 4'hF;
    // Reset: outputs low even with a request presented.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 32'd0);
      chk("rst_resp_valid", resp_valid, 32'd0);
      chk("rst_oe", ram_oe, 32'd0);
      chk("rst_we", ram_we, 32'd0);
      chk("rst_addr", ram_addr, 32'd0);
      chk("rst_wdata", ram_wdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 32'd1);
    chk("post_rst_oe", ram_oe, 32'd0);

    do_req(10'd5, 32'hDEADBEEF, 4'hF);
    do_req(10'd3, 32'hAABBCCDD, 4'hF);
    do_req(10'd9, 32'h00000000, 4'hF);

    // Load of address 5.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd5; req_be = 4'h0; req_wdata = 32'h0;
    @(negedge clk);
    chk("ld_oe", ram_oe, 32'd1);
    chk("ld_we", ram_we, 32'd0);
    chk("ld_addr", ram_addr, 32'd5);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("ld_resp_valid", resp_valid, 32'd1);
    chk("ld_rdata", resp_rdata, 32'hDEADBEEF);
    chk("ld_ready_n1", req_ready, 32'd0);
    @(negedge clk);
    chk("ld_ready_n2", req_ready, 32'd1);
    chk("ld_resp_gone", resp_valid, 32'd0);

    // Full store to 7, then read it back.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd7; req_wdata = 32'h01234567; req_be = 4'hF;
    @(negedge clk);
    chk("fs_we", ram_we, 32'hF);
    chk("fs_wdata", ram_wdata, 32'h01234567);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("fs_resp_valid", resp_valid, 32'd1);
    chk("fs_rdata", resp_rdata, 32'h01234567);
    chk("fs_oe_n1", ram_oe, 32'd0);
    ref_mem[7] = 32'h01234567;
    do_req(10'd7, 32'h0, 4'h0);

    // Partial store be=0101 to 3.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd3; req_wdata = 32'h11223344; req_be = 4'b0101;
    @(negedge clk);
    chk("ps_rd_oe", ram_oe, 32'd1);
    chk("ps_rd_we", ram_we, 32'd0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("ps_wr_we", ram_we, 32'hF);
    chk("ps_wr_addr", ram_addr, 32'd3);
    chk("ps_wr_wdata", ram_wdata, 32'hAA22CC44);
    chk("ps_ready_n1", req_ready, 32'd0);
    @(negedge clk);
    chk("ps_resp_valid", resp_valid, 32'd1);
    chk("ps_rdata", resp_rdata, 32'hAA22CC44);
    ref_mem[3] = 32'hAA22CC44;

    // Back-to-back partial stores to 9 with req_valid held.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd9; req_wdata = 32'hFFFFFFFF; req_be = 4'b0001;
    @(negedge clk);
    chk("b2b_acc1", req_ready, 32'd1);
    @(posedge clk); #1; req_be = 4'b1000;
    @(negedge clk);
    chk("b2b_n1_ready", req_ready, 32'd0);
    chk("b2b_n1_wdata", ram_wdata, 32'h000000FF);
    @(negedge clk);
    chk("b2b_n2_resp", resp_valid, 32'd1);
    chk("b2b_n2_rdata", resp_rdata, 32'h000000FF);
    chk("b2b_n2_ready", req_ready, 32'd0);
    @(negedge clk);
    chk("b2b_n3_ready", req_ready, 32'd1);
    chk("b2b_n3_oe", ram_oe, 32'd1);
    chk("b2b_n3_we", ram_we, 32'd0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_n4_wdata", ram_wdata, 32'hFF0000FF);
    @(negedge clk);
    chk("b2b_n5_resp", resp_valid, 32'd1);
    chk("b2b_n5_rdata", resp_rdata, 32'hFF0000FF);
    chk("b2b_ram9", mem[9], 32'hFF0000FF);
    ref_mem[9] = 32'hFF0000FF;

    // Reset during MERGE aborts the write and the response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd3; req_wdata = 32'h0; req_be = 4'b0011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_oe", ram_oe, 32'd0);
    chk("abort_we", ram_we, 32'd0);
    chk("abort_ready", req_ready, 32'd0);
    chk("abort_wdata", ram_wdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 32'd0);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", req_ready, 32'd1);
    chk("abort_no_resp_after", resp_valid, 32'd0);
    chk("abort_ram3", mem[3], 32'hAA22CC44);
    do_req(10'd3, 32'h0, 4'h0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 1000; n++)
      do_req(10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
